// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add multiply controller beside
// the EX-stage ALU. Stalls the pipeline for XLEN+1 cycles per multiply.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ALU_control     decoded ALU op of the instruction in EX
//   valid_in        EX holds a real instruction (not a bubble)
//   flush           kill the instruction in EX
//   src_a, src_b    multiplicand / multiplier operands
//   stall           freeze PC, IF/ID, ID/EX (combinational)
//   busy            multiply iterations in progress
//   result          low XLEN bits of the last completed product
//   result_valid    one-cycle pulse when result is fresh
module mul_sequencer #(
    parameter int         XLEN     = 32,
    parameter logic [3:0] MUL_CODE = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      ALU_control,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   count;

    logic            start;
    logic            last;
    logic [XLEN-1:0] acc_next;

    assign start = (state_q == IDLE) && valid_in
                   && (ALU_control == MUL_CODE) && !flush;

    // Final iteration: count is about to step from XLEN-1 to XLEN.
    assign last = (count == CW'(XLEN - 1));

    // Partial product for this iteration; carries past XLEN are dropped,
    // which makes signed and unsigned operands produce the same low bits.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    assign stall = start || ((state_q == RUN) && !flush);
    assign busy  = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Same instruction may still sit in EX; never retrigger.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand  <= src_a;
                        mplier <= src_b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    // A flushed multiply leaves result untouched.
                    if (!flush) begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CW'(1);
                        if (last) begin
                            result       <= acc_next;
                            result_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller for the ALU's multiply operation (ALU_control code 1). It sits beside the EX-stage ALU and watches the decoded ALU_control of the instruction in EX. On a valid multiply it stalls the pipeline and runs a radix-2 shift-add over XLEN cycles. It then releases the stall and presents the low XLEN bits of the product for one writeback-eligible cycle.

## Interface
- XLEN, 32, operand/result width.
- MUL_CODE, 4'd1, ALU_control value that selects multiply.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ALU_control  in  4  decoded ALU operation of the instruction in EX.
- valid_in  in  1  EX holds a real (non-bubble) instruction.
- flush  in  1  kill the instruction in EX (branch taken / redirect).
- src_a  in  XLEN  multiplicand operand.
- src_b  in  XLEN  multiplier operand.
- stall  out  1  freeze PC, IF/ID and ID/EX registers (combinational).
- busy  out  1  state is RUN.
- result  out  XLEN  product low bits, registered.
- result_valid  out  1  one-cycle pulse: result is the product of the stalled multiply.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, acc=0, mcand=0, mplier=0, count=0, result=0, result_valid=0.
- start = (state==IDLE) && valid_in && (ALU_control==MUL_CODE) && !flush.
- IDLE: on start latch mcand=src_a, mplier=src_b, acc=0, count=0; go RUN. Otherwise stay; no register changes.
- RUN, each cycle:
  - if mplier[0], acc = acc + mcand (mod 2^XLEN);
  - mcand <<= 1; mplier >>= 1; count += 1.
  - After the cycle where count reaches XLEN-1→XLEN, go DONE and load result with the final acc.
  - Fixed XLEN iterations; no early termination.
- DONE: result_valid=1 for exactly this cycle; go IDLE unconditionally. A start condition in DONE is ignored, so the same instruction cannot retrigger.
- Arithmetic: only the low XLEN bits are kept, so signed and unsigned operands give identical results. count width is clog2(XLEN+1).
- stall = start || (state==RUN && !flush). Low in IDLE (no start) and in DONE.
- busy = (state==RUN).
- Flush in RUN: abort to IDLE next edge, stall drops the same cycle, result unchanged, no result_valid.
- Flush in DONE: result_valid still pulses; the consumer gates writeback with its own flush.
- rst in any state: IDLE next edge, all registers to reset values. stall is 0 in the cycle after reset.
- result holds its value from DONE until the next completed multiply or reset.
- Non-multiply ALU_control codes (2, 4, 5, 6, 7, …) never affect state.

## Timing
- Start accepted in cycle T (stall already high in T).
- RUN occupies cycles T+1 … T+XLEN; DONE is cycle T+XLEN+1.
- stall is high for cycles T … T+XLEN (XLEN+1 cycles) and low in T+XLEN+1, so the pipeline advances out of DONE.
- result and result_valid are valid in T+XLEN+1.
- Back-to-back multiplies: the next multiply's start is at earliest T+XLEN+2, i.e. one cycle after DONE.
- Throughput: one multiply per XLEN+2 cycles.

## Test plan
- Basic multiply: rst 2 cycles, then a valid start with src_a=3, src_b=5 at T → stall high T..T+32, result=15 with result_valid=1 only at T+33, stall=0 at T+33.
- Wrap-around and sign handling:
  - 0xFFFFFFFF×0xFFFFFFFF → result 0x00000001;
  - 0x00010000×0x00010000 → 0x00000000;
  - 12345×0xFFFFFFFF → 0xFFFFCFC7.
- Back-to-back: two multiplies 7×6 then 0×0x1234 → first result 42 at T+33, second start at T+34, result 0 at T+67. Exactly two result_valid pulses; no retrigger in DONE.
- Flush mid-run: start 9×9, assert flush at RUN iteration 10 → stall low that cycle, IDLE next edge, result keeps its prior value, no result_valid within 40 cycles.
- Reset mid-run: start 100×100, assert rst at iteration 5 → next cycle stall=0, busy=0, result=0. A new 2×2 afterwards returns 4 with normal latency.
- Non-multiply and bubble filtering:
  - ALU_control=2/4/6 with valid_in=1 → stall never asserts;
  - ALU_control=1 with valid_in=0, or with flush=1 → no start.
